// File: rtl/image_filter_pkg.sv
// Shared types, sizes and arithmetic helpers for the image filter's window MAC engine.
package image_filter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StFlush = 2'd2
    } mac_state_e;

    localparam int unsigned DEFAULT_M   = 3;
    localparam int unsigned DEFAULT_N   = 3;
    localparam int unsigned KERNEL_SIZE = DEFAULT_M * DEFAULT_N;

    // Wide enough that summing kernel_size full-scale products can never wrap.
    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned kernel_size);
        return 2 * data_width + $clog2(kernel_size);
    endfunction

    function automatic logic fits_signed(input logic signed [63:0] value,
                                         input int unsigned        width);
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (width - 1));
        return (value <= v_max) && (value >= v_min);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int unsigned        width);
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (width - 1));
        if (value > v_max) begin
            return v_max;
        end else if (value < v_min) begin
            return v_min;
        end
        return value;
    endfunction

endpackage

// File: rtl/kernel_regfile.sv
// Kernel coefficient store: synchronous write, combinational read, asynchronous clear to zero.
module kernel_regfile #(
    parameter int unsigned DEPTH      = 9,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wen,
    input  logic [ADDR_WIDTH-1:0]        i_waddr,
    input  logic signed [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0]        i_raddr,
    output logic signed [DATA_WIDTH-1:0] o_rdata
);

    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The index runs one past the last entry while the window drains.
    assign o_rdata = (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/window_mac_engine.sv
// Streaming signed M x N window multiply-accumulate engine.
// Define WINDOW_MAC_SATURATE_EN to clamp out-of-range sums instead of wrapping them.
module window_mac_engine
    import image_filter_pkg::*;
#(
    parameter int unsigned M          = DEFAULT_M,
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic signed [DATA_WIDTH-1:0]   kernel_in,
    input  logic [$clog2(M*N)-1:0]         kernel_addr,
    input  logic                           kernel_wen,
    input  logic signed [DATA_WIDTH-1:0]   pixel_in,
    input  logic                           pixel_valid,
    output logic signed [2*DATA_WIDTH-1:0] matrix_result,
    output logic                           matrix_valid,
    output logic                           busy,
    output logic                           overflow
);

    localparam int unsigned KS     = M * N;
    localparam int unsigned IDX_W  = $clog2(KS);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, KS);

    mac_state_e                   r_state;
    mac_state_e                   w_state_next;
    logic [IDX_W-1:0]             r_idx;
    logic signed [PROD_W-1:0]     r_prod;
    logic signed [PROD_W-1:0]     w_prod;
    logic                         r_prod_vld;
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [PROD_W-1:0]     r_result;
    logic signed [PROD_W-1:0]     w_result;
    logic                         r_valid;
    logic                         r_overflow;
    logic                         w_accept;
    logic                         w_finish;
    logic                         w_kernel_wen;
    logic                         w_fits;
    logic signed [DATA_WIDTH-1:0] w_coef;
    logic signed [63:0]           w_acc_ext;

    kernel_regfile #(
        .DEPTH      (KS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (IDX_W)
    ) u_kernel (
        .clk     (clk),
        .rst     (rst),
        .i_wen   (w_kernel_wen),
        .i_waddr (kernel_addr),
        .i_wdata (kernel_in),
        .i_raddr (r_idx),
        .o_rdata (w_coef)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // start overrides everything, including an in-progress flush and a same-cycle pixel.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_kernel_wen = 1'b0;
        if (start) begin
            w_state_next = StAccum;
        end else begin
            case (r_state)
                StIdle: begin
                    w_kernel_wen = kernel_wen && (32'(kernel_addr) < KS);
                end
                StAccum: begin
                    if (pixel_valid) begin
                        w_accept = 1'b1;
                        if (r_idx == IDX_W'(KS - 1)) begin
                            w_state_next = StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (!r_prod_vld) begin
                        w_finish     = 1'b1;
                        w_state_next = StIdle;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    assign w_prod    = PROD_W'(pixel_in) * PROD_W'(w_coef);
    assign w_acc_ext = 64'(r_acc);
    assign w_fits    = fits_signed(w_acc_ext, PROD_W);

`ifdef WINDOW_MAC_SATURATE_EN
    assign w_result = PROD_W'(saturate(w_acc_ext, PROD_W));
`else
    assign w_result = r_acc[PROD_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_prod_vld <= w_accept;
            r_valid    <= w_finish;
            if (w_accept) begin
                r_prod <= w_prod;
            end
            if (start) begin
                r_idx      <= '0;
                r_acc      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                if (r_prod_vld) begin
                    r_acc <= r_acc + ACC_W'(r_prod);
                end
                if (w_finish) begin
                    r_result   <= w_result;
                    r_overflow <= !w_fits;
                end
            end
        end
    end

    assign matrix_result = r_result;
    assign matrix_valid  = r_valid;
    assign overflow      = r_overflow;
    assign busy          = (r_state != StIdle) || r_valid;

endmodule

// File: tb/tb_window_mac_engine.sv
// Scoreboard bench for window_mac_engine: directed windows, expected results queued at issue.
module tb_window_mac_engine;
    import image_filter_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned KS = KERNEL_SIZE;
`ifdef WINDOW_MAC_SATURATE_EN
    localparam logic [15:0] BIG_EXP = 16'h7FFF;
`else
    localparam logic [15:0] BIG_EXP = 16'h4000;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic signed [DW-1:0]   kernel_in;
    logic [3:0]             kernel_addr;
    logic                   kernel_wen;
    logic signed [DW-1:0]   pixel_in;
    logic                   pixel_valid;
    logic signed [2*DW-1:0] matrix_result;
    logic                   matrix_valid;
    logic                   busy;
    logic                   overflow;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec      = 0;
    int   n_miss     = 0;
    int   cyc        = 0;
    logic prev_valid = 1'b0;

    window_mac_engine #(
        .M          (3),
        .N          (3),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .kernel_in     (kernel_in),
        .kernel_addr   (kernel_addr),
        .kernel_wen    (kernel_wen),
        .pixel_in      (pixel_in),
        .pixel_valid   (pixel_valid),
        .matrix_result (matrix_result),
        .matrix_valid  (matrix_valid),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: every result pulse pops one expectation.
    always @(negedge clk) begin
        if (matrix_valid) begin
            check("valid_pulse_width", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_valid: got result %0h, expected no result",
                         matrix_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {16'd0, matrix_result}, {16'd0, mon_e.res});
                check("result_overflow", 32'(overflow), 32'(mon_e.ovf));
                check("result_cycle", cyc, mon_e.cyc);
            end
        end
        prev_valid = matrix_valid;
    end

    task automatic write_coef(input logic [3:0] a, input logic signed [DW-1:0] v);
        kernel_addr = a;
        kernel_in   = v;
        kernel_wen  = 1'b1;
        @(posedge clk);
        #1;
        kernel_wen  = 1'b0;
    endtask

    task automatic fill_kernel(input logic signed [DW-1:0] v);
        for (int i = 0; i < KS; i++) write_coef(4'(i), v);
    endtask

    task automatic do_start(input logic with_pix, input logic signed [DW-1:0] pv);
        start       = 1'b1;
        pixel_valid = with_pix;
        pixel_in    = pv;
        @(posedge clk);
        #1;
        start       = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic signed [DW-1:0] v);
        pixel_in    = v;
        pixel_valid = 1'b1;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
    endtask

    // Called just after the last pixel's accepting edge: result due two edges later.
    task automatic push_expect(input logic [15:0] res, input logic ovf);
        exp_t e;
        e.res = res;
        e.ovf = ovf;
        e.cyc = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic finish_window(input logic [15:0] res, input logic ovf);
        push_expect(res, ovf);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_in_valid_cycle", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_result", 32'(busy), 32'd0);
        check("valid_dropped", 32'(matrix_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        kernel_in   = '0;
        kernel_addr = '0;
        kernel_wen  = 1'b0;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_result", {16'd0, matrix_result}, 32'd0);
        check("reset_valid", 32'(matrix_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        // Centre tap only: picks out pixel 5.
        for (int i = 0; i < KS; i++) write_coef(4'(i), (i == 4) ? 8'sd1 : 8'sd0);
        do_start(1'b0, 8'sd0);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 1; i <= 9; i++) send_pixel(8'(i));
        finish_window(16'd5, 1'b0);

        // All ones with a 3-cycle gap after pixel 4.
        fill_kernel(8'sd1);
        do_start(1'b0, 8'sd0);
        for (int i = 1; i <= 4; i++) send_pixel(8'(i));
        repeat (3) begin
            @(negedge clk);
            check("busy_gap", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        for (int i = 5; i <= 9; i++) send_pixel(8'(i));
        finish_window(16'd45, 1'b0);

        // All -1 against 127; the pixel presented with start must be dropped.
        fill_kernel(-8'sd1);
        do_start(1'b1, 8'sd50);
        for (int i = 0; i < KS; i++) send_pixel(8'sd127);
        finish_window(16'hFB89, 1'b0);

        // Full-scale negative squares: sum 147456 overflows 16 bits.
        fill_kernel(8'h80);
        do_start(1'b0, 8'sd0);
        for (int i = 0; i < KS; i++) send_pixel(8'h80);
        finish_window(BIG_EXP, 1'b1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Abort after 4 pixels, locked kernel write, then back-to-back windows.
        fill_kernel(8'sd1);
        check("ovf_held_idle", 32'(overflow), 32'd1);
        do_start(1'b0, 8'sd0);
        check("ovf_cleared_by_start", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) send_pixel(8'sd100);
        write_coef(4'd0, 8'sd50);
        do_start(1'b0, 8'sd0);
        for (int i = 1; i <= 9; i++) send_pixel(8'(i));
        push_expect(16'd45, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_back_to_back", 32'(busy), 32'd1);
        for (int i = 0; i < KS; i++) begin
            send_pixel(8'sd2);
            if (i == 3) check("result_held", {16'd0, matrix_result}, 32'd45);
        end
        finish_window(16'd18, 1'b0);

        // Asynchronous reset mid-window clears outputs and kernel.
        do_start(1'b0, 8'sd0);
        send_pixel(8'sd1);
        send_pixel(8'sd2);
        send_pixel(8'sd3);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_result", {16'd0, matrix_result}, 32'd0);
        check("midrst_valid", 32'(matrix_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_start(1'b0, 8'sd0);
        for (int i = 1; i <= 9; i++) send_pixel(8'(i));
        finish_window(16'd0, 1'b0);

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
